pool_frame_arbiter: RTL
=======================

Name: pool_frame_arbiter

Overview:
- Shares one pooling_unit datapath between N_SRC upstream tile streams.
- Grants are frame-granular: one source owns the pooling input for exactly IF_BEATS accepted beats, so the pooling unit never sees interleaved frames.
- Each pooled output frame of OF_BEATS beats is routed back to the destination port matching its source.
- An in-order owner-tag FIFO links input frames to output frames; the arbiter sits between the tile router ports and the pooling_unit instance.

Parameters:
- N_SRC, 4: number of requesting streams (2..8).
- IF_BEATS, 16: input beats per frame (ifsize_x*ifsize_y of the attached pooling unit).
- OF_BEATS, 4: output beats per frame (ofsize_x*ofsize_y).
- TAG_DEPTH, 4: owner-tag FIFO depth, i.e. maximum frames in flight (power of 2, at least 2).

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous reset, active-low.
- src_data_i  in  [N_SRC][`XW] x `QW  per-source channel vectors.
- src_valid_i  in  N_SRC  per-source valid.
- src_ready_o  out  N_SRC  per-source ready.
- pool_data_o  out  [`XW] x `QW  to pooling_unit data_i.
- pool_valid_o  out  1  to pooling_unit valid_i.
- pool_ready_i  in  1  from pooling_unit ready_o.
- pool_data_i  in  [`XW] x `QW  from pooling_unit data_o.
- pool_valid_i  in  1  from pooling_unit valid_o.
- pool_ready_o  out  1  to pooling_unit ready_i.
- dst_data_o  out  [N_SRC][`XW] x `QW  per-destination result data (all ports carry pool_data_i).
- dst_valid_o  out  N_SRC  per-destination valid.
- dst_ready_i  in  N_SRC  per-destination ready.
- owner_o  out  $clog2(N_SRC)  current input owner.
- busy_o  out  1  high in STREAM state.
- pending_o  out  $clog2(TAG_DEPTH)+1  frames waiting for output.
- err_o  out  1  sticky error: pool_valid_i seen while the tag FIFO is empty.

Behaviour:
- Reset (async, rstn low):
  - state=IDLE, owner=0, rr_last=N_SRC-1 (source 0 has highest priority).
  - in_cnt=0, out_cnt=0, tag FIFO empty, err_o=0.
  - All valid/ready outputs drive 0 while rstn is low.
  - Reset mid-frame discards partial frames and all tags; no recovery of the in-flight frame.
- Input FSM, IDLE:
  - Round-robin search over src_valid_i, starting at rr_last+1 mod N_SRC.
  - If any source is requesting and the tag FIFO is not full: owner<=winner, rr_last<=winner, state<=STREAM (one cycle of arbitration latency).
  - If the FIFO is full: stay in IDLE; no grant is issued.
  - All src_ready_o=0 and pool_valid_o=0 in IDLE.
- Input FSM, STREAM:
  - Zero-latency combinational pass-through: pool_data_o=src_data_i[owner], pool_valid_o=src_valid_i[owner], src_ready_o[owner]=pool_ready_i; all other readies 0.
  - in_cnt increments on each pool_valid_o & pool_ready_i.
  - On the beat with in_cnt==IF_BEATS-1: push owner into the tag FIFO, in_cnt<=0, state<=IDLE.
  - The owner holds the grant for the full frame even if its valid deasserts mid-frame; no timeout.
  - A tag push can never overflow, because entry into STREAM required a free slot and only this frame pushes.
- Output path:
  - head = tag FIFO head.
  - dst_valid_o[head] = pool_valid_i & ~empty; other dst_valid_o = 0.
  - pool_ready_o = dst_ready_i[head] & ~empty.
  - out_cnt increments on each pool_valid_i & pool_ready_o.
  - At out_cnt==OF_BEATS-1 with a handshake: pop the FIFO and set out_cnt<=0.
- FIFO edge cases:
  - A push and a pop in the same cycle are both honoured; the count is unchanged.
  - pending_o reflects the registered count, which is TAG_DEPTH when full.
- Error:
  - pool_valid_i=1 while the FIFO is empty sets err_o (sticky until reset).
  - pool_ready_o stays 0 in this case.
- Width rules:
  - in_cnt width is $clog2(IF_BEATS)+1 and out_cnt width is $clog2(OF_BEATS)+1, so no wrap occurs before the terminal compare.
  - FIFO pointers are $clog2(TAG_DEPTH) bits plus one extra wrap bit for full/empty detection.
- Fairness: a continuously requesting source waits at most N_SRC-1 frames before it is granted.

Test Plan:
- Single source 2 valid for 16 beats, pool_ready_i=1 -> grant owner_o=2 one cycle after valid; 16 beats pass unchanged; one tag pushed; 4 output beats reach dst 2 only; pending_o goes 1 then 0.
- All 4 sources valid continuously -> frames granted in order 0,1,2,3,0; each input frame is exactly 16 beats; no interleaving on pool_data_o.
- pool_ready_i toggles 0/1 during a frame and the owner drops valid for 3 cycles -> frame still completes after 16 handshakes; non-owner ready stays 0 throughout.
- Hold dst_ready_i=0 with TAG_DEPTH=4 -> after 4 frames state stays IDLE with pending_o=4; releasing dst_ready_i pops one tag and the next grant follows.
- Push and pop in the same cycle (last input beat coincides with last output beat) -> pending_o is unchanged and the tag order is preserved.
- pool_valid_i pulsed with no frame in flight -> err_o=1 and stays 1; rstn pulse asserted mid-STREAM -> all outputs 0, pending_o=0, err_o=0.

Source files
------------

// File: rtl/pool_frame_arbiter.sv
// rtl/pool_frame_arbiter.sv - frame-granular arbiter sharing one pooling unit between tile streams

module pool_frame_arbiter #(
  parameter int N_SRC     = 4,
  parameter int IF_BEATS  = 16,
  parameter int OF_BEATS  = 4,
  parameter int TAG_DEPTH = 4,
  parameter int XW        = 2,
  parameter int QW        = 8
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic [N_SRC-1:0][XW-1:0][QW-1:0]       src_data_i,
  input  logic [N_SRC-1:0]                       src_valid_i,
  output logic [N_SRC-1:0]                       src_ready_o,
  output logic [XW-1:0][QW-1:0]                  pool_data_o,
  output logic                                   pool_valid_o,
  input  logic                                   pool_ready_i,
  input  logic [XW-1:0][QW-1:0]                  pool_data_i,
  input  logic                                   pool_valid_i,
  output logic                                   pool_ready_o,
  output logic [N_SRC-1:0][XW-1:0][QW-1:0]       dst_data_o,
  output logic [N_SRC-1:0]                       dst_valid_o,
  input  logic [N_SRC-1:0]                       dst_ready_i,
  output logic [$clog2(N_SRC)-1:0]               owner_o,
  output logic                                   busy_o,
  output logic [$clog2(TAG_DEPTH):0]             pending_o,
  output logic                                   err_o
);

  localparam int OW  = $clog2(N_SRC);
  localparam int SW  = OW + 1;
  localparam int PW  = $clog2(TAG_DEPTH);
  localparam int ICW = $clog2(IF_BEATS) + 1;
  localparam int OCW = $clog2(OF_BEATS) + 1;

  localparam logic [ICW-1:0] IN_LAST  = ICW'(IF_BEATS - 1);
  localparam logic [OCW-1:0] OUT_LAST = OCW'(OF_BEATS - 1);
  localparam logic [ICW-1:0] IN_ONE   = ICW'(1);
  localparam logic [OCW-1:0] OUT_ONE  = OCW'(1);
  localparam logic [PW:0]    PTR_ONE  = (PW + 1)'(1);
  localparam logic [SW-1:0]  SUM_N    = SW'(N_SRC);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   rr_last_q, rr_last_d;
  logic [ICW-1:0]  in_cnt_q, in_cnt_d;
  logic [OCW-1:0]  out_cnt_q, out_cnt_d;
  logic [PW:0]     wr_ptr_q, wr_ptr_d;
  logic [PW:0]     rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]   tag_mem_q [TAG_DEPTH];
  logic [OW-1:0]   tag_mem_d [TAG_DEPTH];
  logic            err_q, err_d;

  logic            fifo_empty;
  logic            fifo_full;
  logic [OW-1:0]   head;
  logic            in_hs;
  logic            out_hs;
  logic            push;
  logic            pop;
  logic            rr_found;
  logic [OW-1:0]   rr_winner;
  logic [SW-1:0]   rr_sum;
  logic [OW-1:0]   rr_cand;

  // The extra wrap bit distinguishes full from empty when the index bits match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign head       = tag_mem_q[rd_ptr_q[PW-1:0]];

  assign in_hs      = (state_q == STREAM) && src_valid_i[owner_q] && pool_ready_i;
  assign out_hs     = pool_valid_i && pool_ready_o;

  assign owner_o    = owner_q;
  assign busy_o     = (state_q == STREAM);
  assign pending_o  = wr_ptr_q - rd_ptr_q;
  assign err_o      = err_q;

  // Round-robin search: first requester after the last winner, wrapping mod N_SRC.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = rr_last_q;
    rr_sum    = '0;
    rr_cand   = '0;
    for (int i = 1; i <= N_SRC; i++) begin
      rr_sum = {1'b0, rr_last_q} + SW'(i);
      if (rr_sum >= SUM_N) begin
        rr_sum = rr_sum - SUM_N;
      end
      rr_cand = rr_sum[OW-1:0];
      if (!rr_found && src_valid_i[rr_cand]) begin
        rr_found  = 1'b1;
        rr_winner = rr_cand;
      end
    end
  end

  // Input FSM: grant a whole frame in IDLE, pass the owner through in STREAM.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_last_d    = rr_last_q;
    in_cnt_d     = in_cnt_q;
    push         = 1'b0;
    src_ready_o  = '0;
    pool_valid_o = 1'b0;
    pool_data_o  = src_data_i[owner_q];
    case (state_q)
      IDLE: begin
        // A grant needs a free tag slot so the frame's push can never overflow.
        if (rr_found && !fifo_full) begin
          owner_d   = rr_winner;
          rr_last_d = rr_winner;
          state_d   = STREAM;
        end
      end
      STREAM: begin
        pool_valid_o         = src_valid_i[owner_q];
        src_ready_o[owner_q] = pool_ready_i;
        if (in_hs) begin
          if (in_cnt_q == IN_LAST) begin
            push     = 1'b1;
            in_cnt_d = '0;
            state_d  = IDLE;
          end else begin
            in_cnt_d = in_cnt_q + IN_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output routing: the FIFO head selects which destination sees the pooled frame.
  always_comb begin
    dst_valid_o  = '0;
    pool_ready_o = 1'b0;
    out_cnt_d    = out_cnt_q;
    pop          = 1'b0;
    err_d        = err_q;
    if (!fifo_empty) begin
      dst_valid_o[head] = pool_valid_i;
      pool_ready_o      = dst_ready_i[head];
    end else if (pool_valid_i) begin
      // Output with no frame in flight: flag it and never acknowledge it.
      err_d = 1'b1;
    end
    if (out_hs) begin
      if (out_cnt_q == OUT_LAST) begin
        pop       = 1'b1;
        out_cnt_d = '0;
      end else begin
        out_cnt_d = out_cnt_q + OUT_ONE;
      end
    end
  end

  // Every destination port carries the pooling result; only valid is steered.
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      dst_data_o[i] = pool_data_i;
    end
  end

  // Owner-tag FIFO next state; simultaneous push and pop leave the count unchanged.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    tag_mem_d = tag_mem_q;
    if (push) begin
      tag_mem_d[wr_ptr_q[PW-1:0]] = owner_q;
      wr_ptr_d                    = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // State registers; reset drops any partial frame and every outstanding tag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_last_q <= OW'(N_SRC - 1);
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      err_q     <= err_d;
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_mem_q[i] <= tag_mem_d[i];
      end
    end
  end

endmodule
